// File: rtl/seq_det_param.sv
// Parameterised serial pattern detector with runtime-loadable pattern/length,
// optional overlap, and a saturating match counter.
module seq_det_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter int                 OVERLAP     = 1,
    parameter logic [MAX_LEN-1:0] PAT_DEFAULT = MAX_LEN'(8'b0000_1101),
    parameter int                 LEN_DEFAULT = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       en,
    input  logic                       din,
    input  logic                       cfg_we,
    input  logic [MAX_LEN-1:0]         cfg_pat,
    input  logic [$clog2(MAX_LEN):0]   cfg_len,
    input  logic                       cnt_clr,
    output logic                       out,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       cnt_sat
);

    localparam int LEN_W  = $clog2(MAX_LEN) + 1;
    localparam int LEN_CL = (LEN_DEFAULT < 2) ? 2 :
                            ((LEN_DEFAULT > MAX_LEN) ? MAX_LEN : LEN_DEFAULT);
    localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(LEN_CL);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HUNT
    } state_t;

    state_t             state;
    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] pat_r;
    logic [MAX_LEN-1:0] hist_nx;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   fill_nx;
    logic               adv;
    logic               match;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] v);
        if (v < LEN_W'(2))
            return LEN_W'(2);
        else if (v > LEN_W'(MAX_LEN))
            return LEN_W'(MAX_LEN);
        else
            return v;
    endfunction

    // Match is judged on the post-shift view so out can be a plain register.
    always_comb begin
        mask    = '0;
        hist_nx = (hist << 1) | MAX_LEN'(din);
        fill_nx = (state == HUNT) ? len_r : fill + LEN_W'(1);
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (LEN_W'(i) < len_r);
        adv   = en & ~cfg_we;
        match = adv && (fill_nx == len_r) &&
                (((hist_nx ^ pat_r) & mask) == '0);
    end

    assign cnt_sat = &match_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            hist      <= '0;
            fill      <= '0;
            pat_r     <= PAT_DEFAULT;
            len_r     <= LEN_RST;
            out       <= 1'b0;
            match_cnt <= '0;
        end else begin
            out <= match;

            if (cnt_clr)
                match_cnt <= '0;
            else if (match && !cnt_sat)
                match_cnt <= match_cnt + CNT_W'(1);

            if (cfg_we) begin
                pat_r <= cfg_pat;
                len_r <= clamp_len(cfg_len);
                fill  <= '0;
                state <= IDLE;
            end else if (en) begin
                hist <= hist_nx;
                // Non-overlapping mode demands a fresh len_r bits per match.
                if (match && (OVERLAP == 0)) begin
                    fill  <= '0;
                    state <= IDLE;
                end else begin
                    fill  <= fill_nx;
                    state <= (fill_nx == len_r) ? HUNT : FILL;
                end
            end
        end
    end

endmodule

// File: doc/seq_det_param.md
SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter MAX_LEN, default 8: maximum pattern length in bits, legal range 2..16.
REQ-003 Parameter CNT_W, default 8: width of the match counter.
REQ-004 Parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-005 Parameter PAT_DEFAULT, default 8'b0000_1101: pattern loaded at reset, MAX_LEN bits.
REQ-006 Parameter LEN_DEFAULT, default 4: pattern length loaded at reset.
REQ-007 Port clk, input, 1 bit: rising-edge clock.
REQ-008 Port rstn, input, 1 bit: asynchronous active-low reset.
REQ-009 Port en, input, 1 bit: sample din on this edge.
REQ-010 Port din, input, 1 bit: serial data bit.
REQ-011 Port cfg_we, input, 1 bit: load a new pattern and length.
REQ-012 Port cfg_pat, input, MAX_LEN bits: new pattern, right-aligned. Bit len-1 is the first bit received; bit 0 is the last.
REQ-013 Port cfg_len, input, LEN_W = clog2(MAX_LEN)+1 bits: new pattern length.
REQ-014 Port cnt_clr, input, 1 bit: synchronous clear of the match counter.
REQ-015 Port out, output, 1 bit: registered one-cycle match pulse.
REQ-016 Port match_cnt, output, CNT_W bits: number of matches.
REQ-017 Port cnt_sat, output, 1 bit: high while match_cnt is all-ones.

Function
REQ-018 The block SHALL hold these registers:
- hist: MAX_LEN-bit shift register; din enters at bit 0.
- fill: count of valid history bits, saturating at the active length.
- pat_r: active pattern.
- len_r: active length.
REQ-019 The FSM SHALL have three states:
- IDLE: fill = 0.
- FILL: 0 < fill < len_r.
- HUNT: fill = len_r.
REQ-020 On an edge with en = 1 and cfg_we = 0, the block SHALL:
- shift din into hist;
- increment fill, saturating at len_r;
- move IDLE->FILL, and FILL->HUNT when fill reaches len_r.
REQ-021 A match SHALL occur on an edge where all of the following hold:
- the post-shift fill equals len_r;
- the low len_r bits of the post-shift hist equal the low len_r bits of pat_r.
REQ-022 out SHALL be 1 for exactly the cycle following the matching edge, and 0 otherwise. Back-to-back matches SHALL give consecutive 1s.
REQ-023 With OVERLAP = 1, the FSM SHALL stay in HUNT after a match.
REQ-024 With OVERLAP = 0, a match SHALL set fill to 0 and move the FSM to IDLE, so the next match needs len_r fresh bits.
REQ-025 On an edge with en = 0 and cfg_we = 0, hist, fill and state SHALL hold, and out SHALL be 0. Gaps in en SHALL NOT break a sequence.
REQ-026 On an edge with cfg_we = 1 (this takes precedence over en, and din is ignored), the block SHALL:
- load pat_r from cfg_pat;
- load len_r from cfg_len, with 0 and 1 clamped to 2 and values above MAX_LEN clamped to MAX_LEN;
- set fill to 0 and move to IDLE;
- drive out to 0 in the next cycle.
REQ-027 On each match, match_cnt SHALL increment by 1 and saturate at 2^CNT_W-1. cnt_sat SHALL be combinationally equal to (match_cnt == all-ones).
REQ-028 When cnt_clr = 1, match_cnt SHALL become 0 at the edge. cnt_clr SHALL win over a simultaneous match; out still pulses for that match.

Reset
REQ-029 While rstn = 0, and immediately on its assertion regardless of clk, the block SHALL reset to:
- hist = 0, fill = 0, state IDLE;
- pat_r = PAT_DEFAULT;
- len_r = LEN_DEFAULT, clamped as in REQ-026;
- out = 0, match_cnt = 0, cnt_sat = 0.
REQ-030 A reset mid-sequence SHALL discard partial history; no match SHALL occur until len_r new bits are sampled after release.

Verification
REQ-031 Defaults, en = 1, din = 1,1,0,1 -> out = 1 only in the cycle after the 4th sample; match_cnt = 1.
REQ-032 Overlap: OVERLAP = 1, din = 1,1,0,1,1,0,1 -> out pulses after samples 4 and 7; match_cnt = 2. With OVERLAP = 0, same stream -> one pulse, after sample 4; match_cnt = 1.
REQ-033 en gaps: din = 1,1,0,1 with en = 0 for 3 cycles between each bit -> one pulse after the 4th enabled sample.
REQ-034 Reset mid-op: sample 1,1,0, pulse rstn low for 30 ns, then sample 1 -> out stays 0; match_cnt = 0.
REQ-035 Reconfigure: cfg_we with cfg_pat = 8'b0000_0111, cfg_len = 3, then din = 1,1,1,1 -> pulses after samples 3 and 4 (OVERLAP = 1). A separate write with cfg_len = 0 -> len_r = 2.
REQ-036 Saturation: CNT_W = 2, 4 matches -> match_cnt = 3 and cnt_sat = 1. cnt_clr asserted together with a 5th match -> match_cnt = 0 and out = 1.
